hier_node_rr_aggregator: RTL and testbench
==========================================

Name: hier_node_rr_aggregator

Overview:
- Parametrised hierarchy node: collects word streams from NUM_CHILDREN child instances and merges them into one upstream stream.
- Generalises the fixed five-child structural node into a node with configurable channel count, data width and buffer depth.
- Adds round-robin arbitration, a tagged output FIFO and occupancy/throughput status.
- Nodes chain so each level of the generated hierarchy forwards child traffic toward the root.

Parameters:
NUM_CHILDREN, 5, number of child channels (2..16)
DATA_W, 16, payload width per channel
FIFO_DEPTH, 4, output buffer entries (power of two, >=2)
ID_W, $clog2(NUM_CHILDREN), width of the child-index tag (derived, not overridden)

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  asynchronous assert, active-low reset
child_valid  in  NUM_CHILDREN  per-child word valid
child_data  in  NUM_CHILDREN*DATA_W  child i payload at bits [i*DATA_W +: DATA_W]
child_ready  out  NUM_CHILDREN  per-child accept; at most one bit high per cycle
up_valid  out  1  upstream word available
up_ready  in  1  upstream accept
up_data  out  DATA_W  head payload
up_id  out  ID_W  index of the child that supplied the head word
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy 0..FIFO_DEPTH
accept_count  out  32  total words accepted from children; wraps modulo 2^32

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied; rr_ptr=0; accept_count=0; fifo_level=0; up_valid=0; child_ready=0; up_data and up_id=0. Asserting reset mid-transfer discards all buffered words. No word is accepted in the first cycle after release unless its valid and the grant conditions hold.
- Arbitration (combinational):
  - Search children starting at rr_ptr, ascending, wrapping at NUM_CHILDREN-1 -> 0.
  - The first child with child_valid=1 is the grant.
  - child_ready[grant]=1 only when the FIFO is not full; all other child_ready bits are 0.
- Accept: child_valid[g] & child_ready[g] at a rising edge.
  - Push {g, child_data[g]} into the FIFO.
  - rr_ptr <= (g+1) mod NUM_CHILDREN.
  - accept_count increments.
  - When no accept occurs, rr_ptr holds.
- Full rule: when fifo_level==FIFO_DEPTH, no push occurs, even if a pop happens in the same cycle. Upstream backpressure therefore costs one bubble.
- Upstream side:
  - up_valid = (fifo_level != 0).
  - up_data and up_id show the head entry, driven from registered storage with no combinational path from child inputs.
  - Pop on up_valid & up_ready.
- Latency: a word accepted at edge t is visible on up_* after edge t (next cycle) when the FIFO was empty. Minimum child-to-upstream latency is 1 cycle.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged; order preserved (strict FIFO).
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Level is tracked explicitly, so full and empty are unambiguous.
- Valid/ready protocol:
  - Children must hold valid/data stable until accepted.
  - The node never drops or duplicates a word.
  - up_valid, once high, stays high with stable up_data/up_id until popped. Reset is the only exception.
- Fairness: under continuous contention from all children with the FIFO never full, grants cycle 0,1,...,N-1,0...
- Idle children are skipped with no wasted cycle.
- X-safety: child_data of non-granted channels does not affect any state.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, release with all inputs 0 -> up_valid=0, child_ready=0, fifo_level=0, accept_count=0.
- Single child: child 3 sends 0x00A5 with up_ready=1 -> child_ready[3]=1 that cycle; next cycle up_valid=1, up_data=0x00A5, up_id=3; accept_count=1.
- Full contention, N=5: all children valid continuously, up_ready=1 -> up_id sequence 0,1,2,3,4,0,1; one word per cycle; no child starved.
- Backpressure, DEPTH=4: up_ready=0 and child 1 sends 6 words -> 4 accepted; fifo_level=4; child_ready[1]=0 thereafter. Raising up_ready drains words 1..4 in order, then the remaining 2 follow.
- Skip and wrap: only children 4 and 0 valid, rr_ptr=4 -> grant order 4,0,4,0; rr_ptr wraps from 4 to 0 correctly.
- Mid-operation reset: FIFO holding 3 words, pulse rst_n low asynchronously (not clock-aligned) -> up_valid drops immediately; fifo_level=0; after release the stale words never appear.

Source files
------------

// File: rtl/hier_node_rr_aggregator_if.sv
// Child/upstream bundle for one hierarchy node: per-child valid/ready/data in,
// merged tagged stream plus occupancy/throughput status out.
interface hier_node_rr_aggregator_if #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 4
);
  localparam int ID_W  = $clog2(NUM_CHILDREN);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CHILDREN-1:0]        child_valid;
  logic [NUM_CHILDREN-1:0]        child_ready;
  logic [NUM_CHILDREN*DATA_W-1:0] child_data;
  logic                           up_valid;
  logic                           up_ready;
  logic [DATA_W-1:0]              up_data;
  logic [ID_W-1:0]                up_id;
  logic [LVL_W-1:0]               fifo_level;
  logic [31:0]                    accept_count;

  modport slave (
    input  child_valid, child_data, up_ready,
    output child_ready, up_valid, up_data, up_id, fifo_level, accept_count
  );

  modport master (
    output child_valid, child_data, up_ready,
    input  child_ready, up_valid, up_data, up_id, fifo_level, accept_count
  );
endinterface

// File: rtl/hier_node_rr_aggregator.sv
// Hierarchy node: round-robin merge of NUM_CHILDREN word streams into one
// tagged upstream stream through a small registered FIFO.
module hier_node_rr_aggregator #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int ID_W        = $clog2(NUM_CHILDREN),
  localparam int PTR_W       = $clog2(FIFO_DEPTH),
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  hier_node_rr_aggregator_if.slave bus
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [31:0]       acc_cnt_q;
  entry_t            mem_q [FIFO_DEPTH];

  logic [ID_W-1:0]   cand [NUM_CHILDREN];
  logic [DATA_W-1:0] cdat [NUM_CHILDREN];
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic              full, push, pop;

  // cand[k] = (rr_ptr + k) mod N, the k-th child in search order
  for (genvar k = 0; k < NUM_CHILDREN; k++) begin : g_lane
    logic [ID_W:0] sum;
    assign sum     = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
    assign cand[k] = (sum >= (ID_W+1)'(NUM_CHILDREN))
                   ? ID_W'(sum - (ID_W+1)'(NUM_CHILDREN))
                   : sum[ID_W-1:0];
    assign cdat[k] = bus.child_data[k*DATA_W +: DATA_W];
    assign bus.child_ready[k] = gnt_vld && !full && (gnt_idx == ID_W'(k));
  end

  // Walk the search order backwards so the earliest valid candidate wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
      if (bus.child_valid[cand[k]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  // A full FIFO refuses pushes even when popping, trading one bubble for no
  // combinational path from up_ready to child_ready.
  assign full = (level_q == LVL_W'(FIFO_DEPTH));
  assign push = gnt_vld && !full;
  assign pop  = (level_q != '0) && bus.up_ready;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    rr_ptr_d = rr_ptr_q;
    if (push)
      rr_ptr_d = (gnt_idx == ID_W'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      acc_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      level_q  <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{id: gnt_idx, data: cdat[gnt_idx]};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        acc_cnt_q       <= acc_cnt_q + 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.up_valid     = (level_q != '0);
  assign bus.up_data      = mem_q[rd_ptr_q].data;
  assign bus.up_id        = mem_q[rd_ptr_q].id;
  assign bus.fifo_level   = level_q;
  assign bus.accept_count = acc_cnt_q;

endmodule

// File: tb/tb_hier_node_rr_aggregator.sv
// Directed bench for hier_node_rr_aggregator (N=5, 16-bit data, depth 4).
module tb_hier_node_rr_aggregator;
  localparam int N = 5;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hier_node_rr_aggregator_if #(.NUM_CHILDREN(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  hier_node_rr_aggregator #(.NUM_CHILDREN(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    bus.child_data[ch*DW +: DW] = v;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.child_valid = '0;
    bus.child_data  = '0;
    bus.up_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk); #1;
    tests++; if (bus.up_valid !== 1'b0) begin fails++; $display("FAIL reset_up_valid got %b want 0", bus.up_valid); end
    tests++; if (bus.child_ready !== 5'b0) begin fails++; $display("FAIL reset_child_ready got %b want 00000", bus.child_ready); end
    tests++; if (bus.fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    tests++; if (bus.accept_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.accept_count); end
    tests++; if (bus.up_data !== 16'h0 || bus.up_id !== 3'd0) begin fails++; $display("FAIL reset_head got %h/%0d want 0/0", bus.up_data, bus.up_id); end
  endtask

  task automatic test_single;
    do_reset;
    bus.up_ready = 1'b1;
    bus.child_valid = 5'b01000;
    set_data(3, 16'h00A5);
    #1;
    tests++; if (bus.child_ready !== 5'b01000) begin fails++; $display("FAIL single_ready got %b want 01000", bus.child_ready); end
    @(negedge clk);
    bus.child_valid = '0;
    #1;
    tests++; if (bus.up_valid !== 1'b1 || bus.up_data !== 16'h00A5 || bus.up_id !== 3'd3)
      begin fails++; $display("FAIL single_head got v=%b d=%h id=%0d want v=1 d=00a5 id=3", bus.up_valid, bus.up_data, bus.up_id); end
    tests++; if (bus.accept_count !== 32'd1) begin fails++; $display("FAIL single_count got %0d want 1", bus.accept_count); end
    @(negedge clk); #1;
    tests++; if (bus.up_valid !== 1'b0 || bus.fifo_level !== 3'd0)
      begin fails++; $display("FAIL single_drain got v=%b lvl=%0d want v=0 lvl=0", bus.up_valid, bus.fifo_level); end
  endtask

  task automatic test_contention;
    do_reset;
    bus.up_ready = 1'b1;
    bus.child_valid = '1;
    for (int i = 0; i < N; i++) set_data(i, 16'h0100 + 16'(i));
    #1;
    tests++; if (bus.child_ready !== 5'b00001) begin fails++; $display("FAIL cont_first_ready got %b want 00001", bus.child_ready); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      tests++;
      if (bus.up_valid !== 1'b1 || bus.up_id !== 3'(k % N) || bus.up_data !== 16'h0100 + 16'(k % N)) begin
        fails++;
        $display("FAIL cont_seq[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h", k, bus.up_valid, bus.up_id, bus.up_data, k % N, 16'h0100 + 16'(k % N));
      end
    end
    tests++; if (bus.accept_count !== 32'd7) begin fails++; $display("FAIL cont_count got %0d want 7", bus.accept_count); end
    tests++; if (bus.fifo_level !== 3'd1) begin fails++; $display("FAIL cont_level got %0d want 1", bus.fifo_level); end
    bus.child_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int idx;
    int n;
    logic acc;
    do_reset;
    idx = 0; acc = 1'b0; n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (acc) idx++;
      bus.child_valid = (idx < 6) ? 5'b00010 : 5'b0;
      set_data(1, 16'h0011 + 16'(idx));
      #1 acc = bus.child_ready[1];
    end
    tests++; if (bus.fifo_level !== 3'd4) begin fails++; $display("FAIL bp_level got %0d want 4", bus.fifo_level); end
    tests++; if (bus.child_ready !== 5'b0) begin fails++; $display("FAIL bp_ready_full got %b want 00000", bus.child_ready); end
    tests++; if (bus.accept_count !== 32'd4) begin fails++; $display("FAIL bp_count_full got %0d want 4", bus.accept_count); end
    bus.up_ready = 1'b1;
    for (int c = 0; c < 20 && n < 6; c++) begin
      if (bus.up_valid) begin
        tests++;
        if (bus.up_data !== 16'h0011 + 16'(n) || bus.up_id !== 3'd1) begin
          fails++;
          $display("FAIL bp_order[%0d] got d=%h id=%0d want d=%h id=1", n, bus.up_data, bus.up_id, 16'h0011 + 16'(n));
        end
        n++;
      end
      @(negedge clk);
      if (acc) idx++;
      bus.child_valid = (idx < 6) ? 5'b00010 : 5'b0;
      set_data(1, 16'h0011 + 16'(idx));
      #1 acc = bus.child_ready[1];
    end
    tests++; if (n != 6) begin fails++; $display("FAIL bp_drain_words got %0d want 6", n); end
    tests++; if (bus.accept_count !== 32'd6) begin fails++; $display("FAIL bp_count_end got %0d want 6", bus.accept_count); end
    bus.child_valid = '0;
  endtask

  task automatic test_skip_wrap;
    logic [2:0] g;
    do_reset;
    bus.up_ready = 1'b1;
    bus.child_valid = 5'b01000;
    set_data(3, 16'h0033);
    @(negedge clk);
    bus.child_valid = 5'b10001;
    set_data(4, 16'h0044);
    set_data(0, 16'h0040);
    #1;
    for (int j = 0; j < 4; j++) begin
      g = (j % 2 == 0) ? 3'd4 : 3'd0;
      tests++;
      if (bus.child_ready !== (5'b1 << g)) begin
        fails++; $display("FAIL skip_ready[%0d] got %b want grant %0d", j, bus.child_ready, g);
      end
      @(negedge clk); #1;
      tests++;
      if (bus.up_id !== g || bus.up_valid !== 1'b1) begin
        fails++; $display("FAIL skip_id[%0d] got v=%b id=%0d want v=1 id=%0d", j, bus.up_valid, bus.up_id, g);
      end
    end
    bus.child_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_midreset;
    int stale;
    do_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.child_valid = 5'b00100;
      set_data(2, 16'h0021 + 16'(c));
    end
    @(negedge clk);
    bus.child_valid = '0;
    #1;
    tests++; if (bus.fifo_level !== 3'd3 || bus.up_valid !== 1'b1)
      begin fails++; $display("FAIL mid_prefill got lvl=%0d v=%b want lvl=3 v=1", bus.fifo_level, bus.up_valid); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.up_valid !== 1'b0 || bus.fifo_level !== 3'd0)
      begin fails++; $display("FAIL mid_async got v=%b lvl=%0d want v=0 lvl=0", bus.up_valid, bus.fifo_level); end
    #2 rst_n = 1'b1;
    bus.up_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (bus.up_valid) stale++;
    end
    tests++; if (stale != 0) begin fails++; $display("FAIL mid_stale got %0d stale cycles want 0", stale); end
  endtask

  initial begin
    bus.child_valid = '0;
    bus.child_data  = '0;
    bus.up_ready    = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_skip_wrap;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
